// File: rtl/alu_seq_pkg.sv
//==============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and widths for the ALU command sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam int SEL_W = 4;
    localparam int SEQ_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } seq_state_e;

    // Width-independent part of a FIFO entry; operands are added in the top.
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [SEQ_W-1:0] seq;
    } cmd_tag_t;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
//==============================================================================
// Module      : alu_cmd_fifo
// Description : Power-of-two depth FIFO with combinational head read.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int              c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == c_full_cnt);
    assign empty   = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
//==============================================================================
// Module      : alu_cmd_sequencer
// Description : Buffers ALU commands and issues them one at a time to a
//               registered ALU, returning tagged results.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_op1,
    input  logic [N-1:0]     cmd_op2,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic [N-1:0]     alu_operand1,
    output logic [N-1:0]     alu_operand2,
    output logic [SEL_W-1:0] alu_select,
    input  logic [2*N-1:0]   alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*N-1:0]   rsp_result,
    output logic [SEQ_W-1:0] rsp_seq,
    output logic             busy
);

    typedef struct packed {
        logic [N-1:0] op1;
        logic [N-1:0] op2;
        cmd_tag_t     tag;
    } fifo_entry_t;

    localparam int c_entry_w = $bits(fifo_entry_t);

    seq_state_e           r_state;
    seq_state_e           w_next_state;
    logic [SEQ_W-1:0]     r_accept_cnt;
    logic [SEQ_W-1:0]     r_held_seq;
    logic [c_entry_w-1:0] w_wr_data;
    logic [c_entry_w-1:0] w_rd_data;
    fifo_entry_t          w_head;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_rsp_done;
    logic                 w_full;
    logic                 w_empty;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_wr_data = {cmd_op1, cmd_op2, cmd_sel, r_accept_cnt};
    assign w_head    = w_rd_data;
    assign busy      = (r_state != IDLE) || !w_empty;

    alu_cmd_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_push),
        .wr_data (w_wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (!w_empty) w_next_state = WAIT;
            WAIT:    w_next_state = CAPT;
            CAPT:    w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = w_empty ? IDLE : WAIT;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            IDLE: w_pop = !w_empty;
            CAPT: w_capture = 1'b1;
            RESP: begin
                w_rsp_done = rsp_ready;
                w_pop      = rsp_ready && !w_empty;
            end
            default: ;
        endcase
    end

    // ALU operands only change on a pop, so they stay stable through WAIT/CAPT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_accept_cnt <= '0;
            r_held_seq   <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_select   <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_seq      <= '0;
        end else begin
            if (w_push) r_accept_cnt <= r_accept_cnt + 1'b1;
            if (w_pop) begin
                alu_operand1 <= w_head.op1;
                alu_operand2 <= w_head.op2;
                alu_select   <= w_head.tag.sel;
                r_held_seq   <= w_head.tag.seq;
            end
            if (w_capture) begin
                rsp_result <= alu_result;
                rsp_seq    <= r_held_seq;
                rsp_valid  <= 1'b1;
            end else if (w_rsp_done) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
